// File: rtl/uxn_loader_pkg.sv
// Shared defaults, FSM state type and byte-lane helpers for the Uxn ROM loader.
package uxn_loader_pkg;

    localparam logic [15:0] ROM_BASE_DEFAULT = 16'h0100;
    localparam int          WORD_W           = 32;
    localparam int          OFFS_W           = 16;
    localparam int          ENTRY_W          = OFFS_W + WORD_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        CLEAR,
        DONE
    } ld_state_t;

    typedef logic [1:0] lane_t;

    // Lane 0 is the most significant byte because ROM words arrive big-endian.
    function automatic logic [7:0] lane_byte(input logic [WORD_W-1:0] word, input lane_t lane);
        case (lane)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uxn_rom_word_fifo.sv
// Word FIFO between the bridge write path and the byte serialiser.
// Entries are {offset, data}; head_o shows the oldest entry whenever empty_o is low.
module uxn_rom_word_fifo
    import uxn_loader_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = !flush_i && push_i && (!full_o || pop_i);
    assign do_pop  = !flush_i && pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/uxn_rom_loader.sv
// Uxn ROM loader: buffers big-endian ROM words and writes them one byte per clock into main RAM.
// Define UXN_ROM_LOADER_CLEAR_EN to zero all RAM outside the image before the CPU is released.
module uxn_rom_loader
    import uxn_loader_pkg::*;
#(
    parameter logic [15:0] ROM_BASE   = ROM_BASE_DEFAULT,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_start,
    input  logic        load_end,
    input  logic        wr_valid,
    input  logic [15:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_data,
    output logic        ram_we,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err_overflow,
    output logic        err_range,
    output logic [16:0] rom_size
);

    localparam logic [16:0] BASE17   = {1'b0, ROM_BASE};
    localparam logic [16:0] SIZE_MAX = 17'h10000 - BASE17;

    ld_state_t          state_q;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;

    logic [WORD_W-1:0]  word_q;
    logic [OFFS_W-1:0]  off_q;
    logic [OFFS_W-1:0]  base_off;
    lane_t              lane_q;
    logic               active_q;

    logic [15:0]        ram_addr_q;
    logic [7:0]         ram_data_q;
    logic               ram_we_q;
    logic               cpu_hold_q;
    logic               busy_q;
    logic               done_q;
    logic               err_overflow_q;
    logic               err_range_q;
    logic [16:0]        rom_size_q;

    logic               feeding;
    logic               pop;
    logic               push_try;
    logic               push;
    logic               overflow;
    logic               in_range;
    logic [16:0]        target;
    logic [16:0]        size_cand;

    function automatic logic [16:0] sat_size(input logic [16:0] sz);
        return (sz > SIZE_MAX) ? SIZE_MAX : sz;
    endfunction

`ifdef UXN_ROM_LOADER_CLEAR_EN
    logic [16:0] clr_q;

    // Walk 0..ROM_BASE-1, then jump over the image to ROM_BASE+rom_size..FFFF.
    function automatic logic [16:0] clr_step(input logic [16:0] a, input logic [16:0] size);
        logic [16:0] n;
        n = a + 17'd1;
        if (n == BASE17) n = BASE17 + size;
        return n;
    endfunction
`endif

    assign feeding  = (state_q == LOAD) || (state_q == DRAIN);
    // Pop while idle or during byte 3 so consecutive words stream with no bubble.
    assign pop      = !load_start && feeding && !fifo_empty && (!active_q || (lane_q == 2'd3));
    assign push_try = !load_start && (state_q == LOAD) && wr_valid;
    assign push     = push_try && (!fifo_full || pop);
    assign overflow = push_try && fifo_full && !pop;

    assign base_off  = off_q & 16'hFFFC;
    assign target    = BASE17 + {1'b0, base_off} + {15'd0, lane_q};
    assign size_cand = {1'b0, base_off} + {15'd0, lane_q} + 17'd1;
    assign in_range  = !target[16];

    uxn_rom_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (load_start),
        .push_i      (push),
        .push_data_i ({wr_addr, wr_data}),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (pop) begin
            word_q <= fifo_head[WORD_W-1:0];
            off_q  <= fifo_head[ENTRY_W-1:WORD_W];
            lane_q <= '0;
        end else if (active_q) begin
            lane_q <= lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            active_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_data_q     <= '0;
            ram_we_q       <= 1'b0;
            cpu_hold_q     <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_overflow_q <= 1'b0;
            err_range_q    <= 1'b0;
            rom_size_q     <= '0;
`ifdef UXN_ROM_LOADER_CLEAR_EN
            clr_q          <= '0;
`endif
        end else if (load_start) begin
            state_q        <= LOAD;
            active_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            cpu_hold_q     <= 1'b1;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            err_overflow_q <= 1'b0;
            err_range_q    <= 1'b0;
            rom_size_q     <= '0;
        end else begin
            ram_we_q <= 1'b0;
            if (overflow) err_overflow_q <= 1'b1;

            if (active_q) begin
                if (in_range) begin
                    ram_we_q   <= 1'b1;
                    ram_addr_q <= target[15:0];
                    ram_data_q <= lane_byte(word_q, lane_q);
                    if (size_cand > rom_size_q) rom_size_q <= sat_size(size_cand);
                end else begin
                    err_range_q <= 1'b1;
                end
            end

            if (pop) begin
                active_q <= 1'b1;
            end else if (active_q && (lane_q == 2'd3)) begin
                active_q <= 1'b0;
            end

            case (state_q)
                LOAD: begin
                    if (load_end) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_empty && !active_q) begin
`ifdef UXN_ROM_LOADER_CLEAR_EN
                        state_q <= CLEAR;
                        clr_q   <= (ROM_BASE == 16'h0000) ? rom_size_q : 17'd0;
`else
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
`endif
                    end
                end
`ifdef UXN_ROM_LOADER_CLEAR_EN
                CLEAR: begin
                    if (!clr_q[16]) begin
                        ram_we_q   <= 1'b1;
                        ram_addr_q <= clr_q[15:0];
                        ram_data_q <= 8'h00;
                        clr_q      <= clr_step(clr_q, rom_size_q);
                    end else begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        cpu_hold_q <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign ram_addr     = ram_addr_q;
    assign ram_data     = ram_data_q;
    assign ram_we       = ram_we_q;
    assign cpu_hold     = cpu_hold_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_overflow = err_overflow_q;
    assign err_range    = err_range_q;
    assign rom_size     = rom_size_q;

endmodule

// File: tb/tb_uxn_rom_loader.sv
// Testbench for uxn_rom_loader: directed scenarios plus randomized loads against a queue-based model.
`timescale 1ns/1ps
module tb_uxn_rom_loader;

    localparam logic [15:0] ROM_BASE = 16'h0100;
    localparam int          DEPTH    = 8;
`ifdef UXN_ROM_LOADER_CLEAR_EN
    localparam int          DONE_BOUND = 70000;
`else
    localparam int          DONE_BOUND = 300;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ls, le, wv;
    logic [15:0] wa;
    logic [31:0] wd;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data;
    logic        ram_we, cpu_hold, busy, done, err_overflow, err_range;
    logic [16:0] rom_size;

    always #5 clk = ~clk;

    uxn_rom_loader #(
        .ROM_BASE   (ROM_BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_start   (ls),
        .load_end     (le),
        .wr_valid     (wv),
        .wr_addr      (wa),
        .wr_data      (wd),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .ram_we       (ram_we),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow),
        .err_range    (err_range),
        .rom_size     (rom_size)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] got_q[$];
    int          last_we_cyc = 0;
    int          done_cyc    = 0;
    bit          done_seen   = 0;

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            got_q.push_back({ram_addr, ram_data});
            last_we_cyc = cyc;
        end
        if (done === 1'b1 && !done_seen) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
    end

    // Reference model: a word queue of bounded depth drained 4 bytes per word, one byte per cycle.
    typedef struct packed {
        logic [15:0] off;
        logic [31:0] data;
    } word_t;

    word_t       m_fifo[$];
    word_t       m_cur;
    int          m_left;
    bit          m_loading;
    bit          m_ovf;
    bit          m_rng;
    logic [16:0] m_size;
    logic [23:0] exp_q[$];

    task automatic model_reset();
        m_fifo.delete();
        m_left    = 0;
        m_loading = 0;
        m_ovf     = 0;
        m_rng     = 0;
        m_size    = '0;
    endtask

    task automatic model_emit(int k);
        int         base, t, sz;
        logic [7:0] b;
        base = int'(m_cur.off & 16'hFFFC);
        t    = int'(ROM_BASE) + base + k;
        b    = 8'(m_cur.data >> (8 * (3 - k)));
        if (t <= 65535) begin
            exp_q.push_back({16'(t), b});
            sz = base + k + 1;
            if (sz > 65536 - int'(ROM_BASE)) sz = 65536 - int'(ROM_BASE);
            if (sz > int'(m_size)) m_size = 17'(sz);
        end else begin
            m_rng = 1;
        end
    endtask

    task automatic model_cycle(bit s, bit e, bit v, logic [15:0] a, logic [31:0] d);
        if (s) begin
            model_reset();
            m_loading = 1;
            return;
        end
        if (m_left > 0) begin
            model_emit(4 - m_left);
            m_left--;
        end
        if (m_left == 0 && m_fifo.size() > 0) begin
            m_cur  = m_fifo.pop_front();
            m_left = 4;
        end
        if (m_loading && v) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back({a, d});
            else m_ovf = 1;
        end
        if (m_loading && e) m_loading = 0;
    endtask

    task automatic step(bit s, bit e, bit v, logic [15:0] a, logic [31:0] d);
        @(negedge clk);
        ls = s; le = e; wv = v; wa = a; wd = d;
        model_cycle(s, e, v, a, d);
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests_run++;
        assert (got === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_addr"}, 32'(ram_addr), 32'h0);
        check({tag, "_data"}, 32'(ram_data), 32'h0);
        check({tag, "_we"}, 32'(ram_we), 32'h0);
        check({tag, "_hold"}, 32'(cpu_hold), 32'h1);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_ovf"}, 32'(err_overflow), 32'h0);
        check({tag, "_rng"}, 32'(err_range), 32'h0);
        check({tag, "_size"}, 32'(rom_size), 32'h0);
    endtask

    task automatic wait_done(string tag);
        int n = 0;
        while (done !== 1'b1 && n < DONE_BOUND) begin
            step(0, 0, 0, 16'h0, 32'h0);
            n++;
        end
        check({tag, "_done"}, 32'(done), 32'h1);
        check({tag, "_hold"}, 32'(cpu_hold), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    task automatic compare_stream(string tag);
        int nbad = 0;
`ifdef UXN_ROM_LOADER_CLEAR_EN
        for (int a = 0; a < int'(ROM_BASE); a++) exp_q.push_back({16'(a), 8'h00});
        for (int a = int'(ROM_BASE) + int'(m_size); a <= 65535; a++) exp_q.push_back({16'(a), 8'h00});
`endif
        check({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) nbad++;
        check({tag, "_bad_writes"}, 32'(nbad), 32'h0);
        check({tag, "_size"}, 32'(rom_size), 32'(m_size));
        got_q.delete();
        exp_q.delete();
    endtask

    logic [31:0] w2[16];
    logic [15:0] ra;
    int          nw;
    bit          end_with_word;

    initial begin
        reset_n = 1'b0;
        ls = 0; le = 0; wv = 0; wa = '0; wd = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Single word, exact byte timing.
        done_seen = 0;
        step(1, 0, 0, 16'h0, 32'h0);
        step(0, 0, 1, 16'h0000, 32'h8001A0FF);
        check("t1_busy", 32'(busy), 32'h1);
        step(0, 1, 0, 16'h0, 32'h0);
        step(0, 0, 0, 16'h0, 32'h0);
        check("t1_lat_we0", 32'(ram_we), 32'h0);
        step(0, 0, 0, 16'h0, 32'h0);
        check("t1_b0", {7'd0, ram_we, ram_addr, ram_data}, {7'd0, 1'b1, 16'h0100, 8'h80});
        step(0, 0, 0, 16'h0, 32'h0);
        check("t1_b1", {7'd0, ram_we, ram_addr, ram_data}, {7'd0, 1'b1, 16'h0101, 8'h01});
        step(0, 0, 0, 16'h0, 32'h0);
        check("t1_b2", {7'd0, ram_we, ram_addr, ram_data}, {7'd0, 1'b1, 16'h0102, 8'hA0});
        step(0, 0, 0, 16'h0, 32'h0);
        check("t1_b3", {7'd0, ram_we, ram_addr, ram_data}, {7'd0, 1'b1, 16'h0103, 8'hFF});
        wait_done("t1");
        check("t1_rom_size", 32'(rom_size), 32'd4);
`ifdef UXN_ROM_LOADER_CLEAR_EN
        check("t6_done_lag", 32'(done_cyc - last_we_cyc), 32'd1);
        check("t6_nwrites", 32'(got_q.size()), 32'd65536);
`endif
        compare_stream("t1");

        // 16 back-to-back words into an 8-deep FIFO.
        step(1, 0, 0, 16'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            w2[i] = $urandom;
            step(0, 0, 1, 16'(4 * i), w2[i]);
        end
        step(0, 1, 0, 16'h0, 32'h0);
        wait_done("t2");
        check("t2_ovf", 32'(err_overflow), 32'h1);
        check("t2_ge40", 32'(got_q.size() >= 40), 32'h1);
        if (got_q.size() >= 40) check("t2_w9_last", 32'(got_q[39]), {8'd0, 16'h0127, w2[9][7:0]});
        compare_stream("t2");

        // Top of RAM and the range boundary.
        step(1, 0, 0, 16'h0, 32'h0);
        step(0, 0, 1, 16'hFEFC, 32'h11223344);
        step(0, 0, 1, 16'hFF00, 32'h55667788);
        step(0, 1, 0, 16'h0, 32'h0);
        wait_done("t3");
        check("t3_rng", 32'(err_range), 32'h1);
        check("t3_rom_size", 32'(rom_size), 32'h0FF00);
`ifndef UXN_ROM_LOADER_CLEAR_EN
        check("t3_nwr", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) check("t3_last", 32'(got_q[3]), {8'd0, 16'hFFFF, 8'h44});
`endif
        compare_stream("t3");

        // Abort after byte 1 of the second word; a third word sits in the FIFO and must be flushed.
        step(1, 0, 0, 16'h0, 32'h0);
        step(0, 0, 1, 16'hFF00, $urandom);
        step(0, 0, 1, 16'h0000, $urandom);
        step(0, 0, 1, 16'h0004, $urandom);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0, 32'h0);
        check("t4_rng_before", 32'(err_range), 32'h1);
        step(1, 0, 0, 16'h0, 32'h0);
        step(0, 0, 0, 16'h0, 32'h0);
        check("t4_rng_clr", 32'(err_range), 32'h0);
        check("t4_hold", 32'(cpu_hold), 32'h1);
        check("t4_done", 32'(done), 32'h0);
        check("t4_size_clr", 32'(rom_size), 32'h0);
        check("t4_nwr_abort", 32'(got_q.size()), 32'd2);
        step(0, 0, 1, 16'h0008, $urandom);
        step(0, 1, 0, 16'h0, 32'h0);
        wait_done("t4");
        compare_stream("t4");

        // Asynchronous reset in the middle of a load.
        step(1, 0, 0, 16'h0, 32'h0);
        step(0, 0, 1, 16'h0000, $urandom);
        step(0, 0, 1, 16'h0004, $urandom);
        step(0, 0, 0, 16'h0, 32'h0);
        step(0, 0, 0, 16'h0, 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("t5_async");
        @(posedge clk);
        #2 reset_n = 1'b1;
        model_reset();
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 12; i++) step(0, 0, 1, 16'(4 * i), $urandom);
        step(0, 0, 0, 16'h0, 32'h0);
        check("t5_no_we", 32'(got_q.size()), 32'd0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_hold", 32'(cpu_hold), 32'h1);

        // Randomized loads.
        for (int r = 0; r < 4; r++) begin
            step(1, 0, 0, 16'h0, 32'h0);
            nw            = int'($urandom_range(3, 14));
            end_with_word = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < nw; i++) begin
                if ($urandom_range(0, 2) == 0) step(0, 0, 0, 16'h0, 32'h0);
                if ($urandom_range(0, 3) == 0) ra = 16'($urandom_range(16'hFEF0, 16'hFFFF));
                else ra = 16'($urandom_range(0, 16'h03FF));
                step(0, (i == nw - 1) && end_with_word, 1, ra, $urandom);
            end
            if (!end_with_word) step(0, 1, 0, 16'h0, 32'h0);
            wait_done("rnd");
            check("rnd_ovf", 32'(err_overflow), 32'(m_ovf));
            check("rnd_rng", 32'(err_range), 32'(m_rng));
            compare_stream("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
